// File: rtl/chess_clock_timer.sv
// Per-player BCD MM:SS countdown timer with a one-second prescaler and a Fischer increment.
// Paused/running control comes from the chess clock FSM; o_zero feeds back to it.
module chess_clock_timer #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned START_MIN = 5,
    parameter int unsigned START_SEC = 0,
    parameter int unsigned INC_SEC   = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_restart,
    input  logic       i_stop,
    output logic       o_zero,
    output logic       o_running,
    output logic       o_tick,
    output logic [3:0] o_min_tens,
    output logic [3:0] o_min_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_sec_ones
);

    localparam int unsigned    PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PreMax   = PW'(TICK_DIV - 1);
    localparam int unsigned    CW       = $clog2(INC_SEC + 2);
    localparam logic [CW-1:0]  IncLast  = CW'((INC_SEC > 0) ? (INC_SEC - 1) : 0);
    localparam bit             HasInc   = (INC_SEC > 0);
    localparam logic [15:0]    StartBcd = {4'(START_MIN / 10), 4'(START_MIN % 10),
                                           4'(START_SEC / 10), 4'(START_SEC % 10)};
    localparam logic [15:0]    MaxBcd   = 16'h9959;

    typedef enum logic [1:0] {StPaused, StRunning, StAdd, StExpired} state_e;

    state_e          r_state, w_state_d;
    logic [PW-1:0]   r_pre, w_pre_d;
    logic [CW-1:0]   r_cnt, w_cnt_d;
    logic [15:0]     r_time, w_time_d;
    logic            r_zero, r_running, r_tick;
    logic            w_tick_d;
    logic [15:0]     w_dec, w_inc;

    // Digits packed as {min_tens, min_ones, sec_tens, sec_ones}.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = (mt != 4'd0) ? mt - 4'd1 : 4'd9;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // Saturating at 99:59 keeps every digit inside its legal range.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (t == MaxBcd) begin
            return t;
        end
        if (so != 4'd9) begin
            so = so + 4'd1;
        end else begin
            so = 4'd0;
            if (st != 4'd5) begin
                st = st + 4'd1;
            end else begin
                st = 4'd0;
                if (mo != 4'd9) begin
                    mo = mo + 4'd1;
                end else begin
                    mo = 4'd0;
                    mt = mt + 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign w_dec = bcd_dec(r_time);
    assign w_inc = bcd_inc(r_time);

    always_comb begin
        w_state_d = r_state;
        w_pre_d   = r_pre;
        w_cnt_d   = r_cnt;
        w_time_d  = r_time;
        w_tick_d  = 1'b0;
        if (i_restart) begin
            w_state_d = StPaused;
            w_pre_d   = '0;
            w_cnt_d   = '0;
            w_time_d  = StartBcd;
        end else begin
            unique case (r_state)
                StPaused: begin
                    if (!i_stop) begin
                        w_state_d = (r_time == 16'h0000) ? StExpired : StRunning;
                    end
                end
                StRunning: begin
                    // Stop beats the terminal count; the prescaler stays at PreMax.
                    if (i_stop) begin
                        w_state_d = HasInc ? StAdd : StPaused;
                    end else if (r_pre == PreMax) begin
                        w_pre_d  = '0;
                        w_time_d = w_dec;
                        w_tick_d = 1'b1;
                        if (w_dec == 16'h0000) begin
                            w_state_d = StExpired;
                        end
                    end else begin
                        w_pre_d = r_pre + 1'b1;
                    end
                end
                StAdd: begin
                    w_time_d = w_inc;
                    if (r_time == MaxBcd || w_inc == MaxBcd || r_cnt == IncLast) begin
                        w_state_d = StPaused;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                StExpired: begin
                end
                default: begin
                    w_state_d = StPaused;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StPaused;
            r_pre     <= '0;
            r_cnt     <= '0;
            r_time    <= StartBcd;
            r_zero    <= (StartBcd == 16'h0000);
            r_running <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_pre     <= w_pre_d;
            r_cnt     <= w_cnt_d;
            r_time    <= w_time_d;
            r_zero    <= (w_time_d == 16'h0000);
            r_running <= (w_state_d == StRunning);
            r_tick    <= w_tick_d;
        end
    end

    assign o_zero     = r_zero;
    assign o_running  = r_running;
    assign o_tick     = r_tick;
    assign o_min_tens = r_time[15:12];
    assign o_min_ones = r_time[11:8];
    assign o_sec_tens = r_time[7:4];
    assign o_sec_ones = r_time[3:0];

endmodule

// File: tb/tb_chess_clock_timer.sv
// Directed bench for chess_clock_timer: a vector table on a 00:03/+2 s instance plus
// short sequences on 99:59, 10:00 and 00:00 instances.
module tb_chess_clock_timer;

    typedef struct {
        logic        stop;
        logic        restart;
        logic [15:0] digits;
        logic        zero;
        logic        running;
        logic        tick;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic restart = 1'b0;
    logic stop_a = 1'b1, stop_b = 1'b1, stop_c = 1'b1, stop_d = 1'b1;

    logic       zero_a, run_a, tick_a, zero_b, run_b, tick_b;
    logic       zero_c, run_c, tick_c, zero_d, run_d, tick_d;
    logic [3:0] mt_a, mo_a, st_a, so_a, mt_b, mo_b, st_b, so_b;
    logic [3:0] mt_c, mo_c, st_c, so_c, mt_d, mo_d, st_d, so_d;

    int n_pass = 0;
    int n_total = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    chess_clock_timer #(.TICK_DIV(4), .START_MIN(0), .START_SEC(3), .INC_SEC(2)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart), .i_stop(stop_a),
        .o_zero(zero_a), .o_running(run_a), .o_tick(tick_a),
        .o_min_tens(mt_a), .o_min_ones(mo_a), .o_sec_tens(st_a), .o_sec_ones(so_a)
    );
    chess_clock_timer #(.TICK_DIV(4), .START_MIN(99), .START_SEC(59), .INC_SEC(2)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart), .i_stop(stop_b),
        .o_zero(zero_b), .o_running(run_b), .o_tick(tick_b),
        .o_min_tens(mt_b), .o_min_ones(mo_b), .o_sec_tens(st_b), .o_sec_ones(so_b)
    );
    chess_clock_timer #(.TICK_DIV(4), .START_MIN(10), .START_SEC(0), .INC_SEC(2)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart), .i_stop(stop_c),
        .o_zero(zero_c), .o_running(run_c), .o_tick(tick_c),
        .o_min_tens(mt_c), .o_min_ones(mo_c), .o_sec_tens(st_c), .o_sec_ones(so_c)
    );
    chess_clock_timer #(.TICK_DIV(4), .START_MIN(0), .START_SEC(0), .INC_SEC(0)) u_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart), .i_stop(stop_d),
        .o_zero(zero_d), .o_running(run_d), .o_tick(tick_d),
        .o_min_tens(mt_d), .o_min_ones(mo_d), .o_sec_tens(st_d), .o_sec_ones(so_d)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic addv(input int n, input logic s, input logic r, input logic [15:0] d,
                        input logic z, input logic run, input logic t);
        for (int k = 0; k < n; k++) begin
            vq.push_back('{stop: s, restart: r, digits: d, zero: z, running: run, tick: t});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stop, restart, digits, zero, running, tick (sampled after the edge)
        addv(2, 1, 0, 16'h0003, 0, 0, 0);  // reset state held while paused
        addv(4, 0, 0, 16'h0003, 0, 1, 0);
        addv(1, 0, 0, 16'h0002, 0, 1, 1);
        addv(3, 0, 0, 16'h0002, 0, 1, 0);
        addv(1, 0, 0, 16'h0001, 0, 1, 1);
        addv(3, 0, 0, 16'h0001, 0, 1, 0);
        addv(1, 0, 0, 16'h0000, 1, 0, 1);  // expires
        addv(1, 1, 0, 16'h0000, 1, 0, 0);
        addv(1, 0, 0, 16'h0000, 1, 0, 0);
        addv(1, 1, 0, 16'h0000, 1, 0, 0);
        addv(1, 0, 1, 16'h0003, 0, 0, 0);  // restart out of EXPIRED with stop=0
        addv(4, 0, 0, 16'h0003, 0, 1, 0);
        addv(1, 0, 0, 16'h0002, 0, 1, 1);
        addv(1, 0, 0, 16'h0002, 0, 1, 0);  // prescaler mid-count
        addv(1, 1, 0, 16'h0002, 0, 0, 0);  // into ADD
        addv(1, 1, 0, 16'h0003, 0, 0, 0);
        addv(2, 1, 0, 16'h0004, 0, 0, 0);
        addv(3, 0, 0, 16'h0004, 0, 1, 0);
        addv(1, 0, 0, 16'h0003, 0, 1, 1);  // early tick: partial second kept
        addv(1, 0, 1, 16'h0003, 0, 0, 0);  // restart while RUNNING
        addv(1, 0, 0, 16'h0003, 0, 1, 0);
        addv(1, 1, 0, 16'h0003, 0, 0, 0);
        addv(1, 1, 1, 16'h0003, 0, 0, 0);  // restart while ADD
        addv(1, 1, 0, 16'h0003, 0, 0, 0);
        addv(4, 0, 0, 16'h0003, 0, 1, 0);
        addv(1, 1, 0, 16'h0003, 0, 0, 0);  // stop at terminal count
        addv(1, 1, 0, 16'h0004, 0, 0, 0);
        addv(1, 1, 0, 16'h0005, 0, 0, 0);
        addv(1, 0, 0, 16'h0005, 0, 1, 0);
        addv(1, 0, 0, 16'h0004, 0, 1, 1);  // deferred decrement
        addv(3, 0, 0, 16'h0004, 0, 1, 0);
        addv(1, 0, 1, 16'h0003, 0, 0, 0);  // restart beats pending tick

        #12 rst_n = 1'b1;
        check("reset digits", {mt_a, mo_a, st_a, so_a}, 16'h0003);
        check("reset zero", 16'(zero_a), 16'h0);
        check("reset start00 zero", 16'(zero_d), 16'h1);

        for (int i = 0; i < vq.size(); i++) begin
            stop_a  = vq[i].stop;
            restart = vq[i].restart;
            step();
            check($sformatf("v%0d digits", i), {mt_a, mo_a, st_a, so_a}, vq[i].digits);
            check($sformatf("v%0d zero", i), 16'(zero_a), 16'(vq[i].zero));
            check($sformatf("v%0d running", i), 16'(run_a), 16'(vq[i].running));
            check($sformatf("v%0d tick", i), 16'(tick_a), 16'(vq[i].tick));
        end
        restart = 1'b0;

        // Asynchronous reset in the middle of a count
        stop_a = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async rst digits", {mt_a, mo_a, st_a, so_a}, 16'h0003);
        check("async rst running", 16'(run_a), 16'h0);
        stop_a = 1'b1;
        #1 rst_n = 1'b1;

        // 99:59 saturates in ADD and leaves after one cycle
        stop_b = 1'b0;
        step();
        check("b running", 16'(run_b), 16'h1);
        step();
        stop_b = 1'b1;
        step();
        check("b add digits", {mt_b, mo_b, st_b, so_b}, 16'h9959);
        step();
        check("b sat digits", {mt_b, mo_b, st_b, so_b}, 16'h9959);
        stop_b = 1'b0;
        step();
        check("b resumed after 1-cycle add", 16'(run_b), 16'h1);
        stop_b = 1'b1;

        // 10:00 borrows across every digit
        stop_c = 1'b0;
        repeat (4) step();
        check("c pre-tick digits", {mt_c, mo_c, st_c, so_c}, 16'h1000);
        step();
        check("c tick digits", {mt_c, mo_c, st_c, so_c}, 16'h0959);
        check("c tick pulse", 16'(tick_c), 16'h1);
        stop_c = 1'b1;

        // 00:00 start goes straight to EXPIRED
        stop_d = 1'b0;
        step();
        check("d expired running", 16'(run_d), 16'h0);
        check("d expired zero", 16'(zero_d), 16'h1);
        stop_d = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
